// File: rtl/fm_playback_gen_if.sv
// rtl/fm_playback_gen_if.sv - valid/ready playback stream between the generator and user-logic input
interface fm_playback_gen_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fm_playback_gen.sv
// rtl/fm_playback_gen.sv - FM spy-buffer playback transmitter: RAM replay in single or loop mode
module fm_playback_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_hs,
  input  logic                  rst_hs,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_reject,
  input  logic [1:0]            playback_mode,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic [15:0]           loop_count,
  fm_playback_gen_if.master     stream
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_nxt;
  logic                  loop_q;
  logic                  wrap_q;
  logic                  mode_ok;
  logic                  start_ok;
  logic                  accept;
  logic                  at_last;

  assign mode_ok  = (playback_mode == 2'd1) || (playback_mode == 2'd2);
  assign start_ok = (state_q == IDLE) && start && !stop && mode_ok;
  assign accept   = (state_q == PLAY) && stream.out_ready;
  assign at_last  = (idx_q == last_q);
  // The index wraps at the latched last address, never by counter overflow.
  assign idx_nxt  = at_last ? '0 : idx_q + 1'b1;

  assign busy             = (state_q != IDLE);
  assign stream.out_valid = (state_q == PLAY);
  assign stream.out_data  = data_q;
  assign stream.out_last  = (state_q == PLAY) && at_last;

  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FETCH;
      FETCH:   state_d = PLAY;
      PLAY:    if (accept && at_last && !loop_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Storage is intentionally not reset; writes only land while idle.
  always_ff @(posedge clk_hs) begin
    if (wr_en && (state_q == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      data_q     <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      loop_q     <= 1'b0;
      wrap_q     <= 1'b0;
      loop_count <= '0;
      wr_reject  <= 1'b0;
    end else begin
      wr_reject <= wr_en && busy;
      if (start_ok) begin
        last_q     <= last_addr;
        loop_q     <= (playback_mode == 2'd2);
        loop_count <= '0;
      end
      if (state_q == FETCH) begin
        data_q <= mem[0];
        idx_q  <= '0;
        wrap_q <= 1'b0;
      end else if (accept && !stop) begin
        data_q <= mem[idx_nxt];
        idx_q  <= idx_nxt;
        wrap_q <= at_last;
        // A pass counts as complete once the first word of the following pass is taken.
        if (wrap_q && (loop_count != 16'hFFFF)) begin
          loop_count <= loop_count + 16'd1;
        end
      end
    end
  end

endmodule
